// File: rtl/reservation_station.sv
// ============================================================================
// Module   : reservation_station
// Purpose  : ALU/branch reservation station with CDB wake-up and
//            lowest-index dispatch of one fully-ready entry per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clr,
  input  logic               issue_valid,
  input  logic [OP_LOG-1:0]  issue_op,
  input  logic [ROB_LOG-1:0] issue_RobId,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_imm,
  input  logic [31:0]        issue_Vj,
  input  logic [31:0]        issue_Vk,
  input  logic               issue_Rj,
  input  logic               issue_Rk,
  input  logic [ROB_LOG-1:0] issue_Qj,
  input  logic [ROB_LOG-1:0] issue_Qk,
  input  logic               alu_valid,
  input  logic [ROB_LOG-1:0] alu_RobId,
  input  logic [31:0]        alu_value,
  input  logic               lsb_valid,
  input  logic [ROB_LOG-1:0] lsb_RobId,
  input  logic [31:0]        lsb_value,
  output logic               rs_full,
  output logic               ex_valid,
  output logic [OP_LOG-1:0]  ex_op,
  output logic [31:0]        ex_Vj,
  output logic [31:0]        ex_Vk,
  output logic [31:0]        ex_imm,
  output logic [31:0]        ex_pc,
  output logic [ROB_LOG-1:0] ex_RobId
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] C_FULL_MARK = CNT_W'(RS_SIZE - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  logic               r_busy [RS_SIZE];
  logic [OP_LOG-1:0]  r_op   [RS_SIZE];
  logic [ROB_LOG-1:0] r_rob  [RS_SIZE];
  logic [31:0]        r_pc   [RS_SIZE];
  logic [31:0]        r_imm  [RS_SIZE];
  logic [31:0]        r_vj   [RS_SIZE];
  logic [31:0]        r_vk   [RS_SIZE];
  logic               r_rj   [RS_SIZE];
  logic               r_rk   [RS_SIZE];
  logic [ROB_LOG-1:0] r_qj   [RS_SIZE];
  logic [ROB_LOG-1:0] r_qk   [RS_SIZE];
  logic [CNT_W-1:0]   r_count;

  logic             w_sel_found, w_free_found, w_issue_ok;
  logic [IDX_W-1:0] w_sel_idx, w_free_idx;
  logic [CNT_W-1:0] w_count_next;
  logic             w_in_rj, w_in_rk;
  logic [31:0]      w_in_vj, w_in_vk;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (r_busy[i] && r_rj[i] && r_rk[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Catch a producer broadcasting on the very cycle its consumer issues.
  always_comb begin
    w_in_rj = issue_Rj;
    w_in_vj = issue_Vj;
    w_in_rk = issue_Rk;
    w_in_vk = issue_Vk;
    if (!issue_Rj) begin
      if (alu_valid && alu_RobId == issue_Qj) begin
        w_in_rj = 1'b1;
        w_in_vj = alu_value;
      end else if (lsb_valid && lsb_RobId == issue_Qj) begin
        w_in_rj = 1'b1;
        w_in_vj = lsb_value;
      end
    end
    if (!issue_Rk) begin
      if (alu_valid && alu_RobId == issue_Qk) begin
        w_in_rk = 1'b1;
        w_in_vk = alu_value;
      end else if (lsb_valid && lsb_RobId == issue_Qk) begin
        w_in_rk = 1'b1;
        w_in_vk = lsb_value;
      end
    end
  end

  assign w_issue_ok = issue_valid && w_free_found;

  always_comb begin
    w_count_next = r_count;
    if (w_issue_ok && !w_sel_found) begin
      w_count_next = r_count + C_CNT_ONE;
    end else if (!w_issue_ok && w_sel_found) begin
      w_count_next = r_count - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      rs_full  <= 1'b0;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_Vj    <= '0;
      ex_Vk    <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
      ex_RobId <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i] <= 1'b0;
        r_op[i]   <= '0;
        r_rob[i]  <= '0;
        r_pc[i]   <= '0;
        r_imm[i]  <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_rj[i]   <= 1'b0;
        r_rk[i]   <= 1'b0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
      end
    end else if (rdy) begin
      if (clr) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          r_busy[i] <= 1'b0;
        end
        r_count  <= '0;
        rs_full  <= 1'b0;
        ex_valid <= 1'b0;
      end else begin
        // ALU wins when both buses carry the same tag.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !r_rj[i]) begin
            if (alu_valid && alu_RobId == r_qj[i]) begin
              r_rj[i] <= 1'b1;
              r_vj[i] <= alu_value;
            end else if (lsb_valid && lsb_RobId == r_qj[i]) begin
              r_rj[i] <= 1'b1;
              r_vj[i] <= lsb_value;
            end
          end
          if (r_busy[i] && !r_rk[i]) begin
            if (alu_valid && alu_RobId == r_qk[i]) begin
              r_rk[i] <= 1'b1;
              r_vk[i] <= alu_value;
            end else if (lsb_valid && lsb_RobId == r_qk[i]) begin
              r_rk[i] <= 1'b1;
              r_vk[i] <= lsb_value;
            end
          end
        end
        if (w_sel_found) begin
          ex_valid          <= 1'b1;
          ex_op             <= r_op[w_sel_idx];
          ex_Vj             <= r_vj[w_sel_idx];
          ex_Vk             <= r_vk[w_sel_idx];
          ex_imm            <= r_imm[w_sel_idx];
          ex_pc             <= r_pc[w_sel_idx];
          ex_RobId          <= r_rob[w_sel_idx];
          r_busy[w_sel_idx] <= 1'b0;
        end else begin
          ex_valid <= 1'b0;
        end
        // The free slot is never the dispatched one: selection needs busy=1.
        if (w_issue_ok) begin
          r_busy[w_free_idx] <= 1'b1;
          r_op[w_free_idx]   <= issue_op;
          r_rob[w_free_idx]  <= issue_RobId;
          r_pc[w_free_idx]   <= issue_pc;
          r_imm[w_free_idx]  <= issue_imm;
          r_vj[w_free_idx]   <= w_in_vj;
          r_vk[w_free_idx]   <= w_in_vk;
          r_rj[w_free_idx]   <= w_in_rj;
          r_rk[w_free_idx]   <= w_in_rk;
          r_qj[w_free_idx]   <= issue_Qj;
          r_qk[w_free_idx]   <= issue_Qk;
        end
        r_count <= w_count_next;
        rs_full <= (w_count_next >= C_FULL_MARK);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Self-checking bench for reservation_station: vector table,
//            directed corner sequences and randomized traffic vs. a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reservation_station;

  localparam int N = 16;

  logic        clk, rst, rdy, clr, issue_valid;
  logic [5:0]  issue_op;
  logic [3:0]  issue_RobId, issue_Qj, issue_Qk;
  logic [31:0] issue_pc, issue_imm, issue_Vj, issue_Vk;
  logic        issue_Rj, issue_Rk;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_RobId, lsb_RobId;
  logic [31:0] alu_value, lsb_value;
  logic        rs_full, ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_Vj, ex_Vk, ex_imm, ex_pc;
  logic [3:0]  ex_RobId;

  reservation_station #(.RS_SIZE(N), .ROB_LOG(4), .OP_LOG(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_RobId(issue_RobId),
    .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .alu_valid(alu_valid), .alu_RobId(alu_RobId), .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_RobId(lsb_RobId), .lsb_value(lsb_value),
    .rs_full(rs_full), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_Vj(ex_Vj), .ex_Vk(ex_Vk), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_RobId(ex_RobId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  rob;
    logic [31:0] pc, imm, vj, vk;
    logic        rj, rk;
    logic [3:0]  qj, qk;
  } ent_t;

  ent_t m_e    [N];
  logic m_busy [N];
  ent_t m_ex;
  logic m_exv, m_full;
  int   m_count;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_e[i]    = '0;
    end
    m_ex = '0; m_exv = 1'b0; m_full = 1'b0; m_count = 0;
  endtask

  // An operand waiting on tag q becomes ready if a bus carries q; ALU first.
  function automatic void snoop(input logic r, input logic [3:0] q, input logic [31:0] v,
                                output logic ro, output logic [31:0] vo);
    ro = r; vo = v;
    if (!r) begin
      if (alu_valid && alu_RobId == q) begin ro = 1'b1; vo = alu_value; end
      else if (lsb_valid && lsb_RobId == q) begin ro = 1'b1; vo = lsb_value; end
    end
  endfunction

  task automatic model_edge();
    int sel, fr;
    logic nr;
    logic [31:0] nv;
    ent_t ne;
    if (!rdy) return;
    if (clr) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_count = 0; m_exv = 1'b0; m_full = 1'b0;
      return;
    end
    sel = -1; fr = -1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && m_busy[i] && m_e[i].rj && m_e[i].rk) sel = i;
      if (fr < 0 && !m_busy[i]) fr = i;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        snoop(m_e[i].rj, m_e[i].qj, m_e[i].vj, nr, nv); m_e[i].rj = nr; m_e[i].vj = nv;
        snoop(m_e[i].rk, m_e[i].qk, m_e[i].vk, nr, nv); m_e[i].rk = nr; m_e[i].vk = nv;
      end
    end
    if (sel >= 0) begin
      m_exv = 1'b1; m_ex = m_e[sel]; m_busy[sel] = 1'b0; m_count--;
    end else begin
      m_exv = 1'b0;
    end
    if (issue_valid) begin
      check("issue_has_free_slot", 32'(fr >= 0), 32'd1);
      if (fr >= 0) begin
        ne.op = issue_op; ne.rob = issue_RobId; ne.pc = issue_pc; ne.imm = issue_imm;
        ne.qj = issue_Qj; ne.qk = issue_Qk;
        snoop(issue_Rj, issue_Qj, issue_Vj, nr, nv); ne.rj = nr; ne.vj = nv;
        snoop(issue_Rk, issue_Qk, issue_Vk, nr, nv); ne.rk = nr; ne.vk = nv;
        m_e[fr] = ne; m_busy[fr] = 1'b1; m_count++;
      end
    end
    m_full = (m_count >= N - 1);
  endtask

  task automatic compare_model();
    check("m_ex_valid", 32'(ex_valid), 32'(m_exv));
    check("m_rs_full",  32'(rs_full),  32'(m_full));
    check("m_ex_RobId", 32'(ex_RobId), 32'(m_ex.rob));
    check("m_ex_op",    32'(ex_op),    32'(m_ex.op));
    check("m_ex_Vj",    ex_Vj,  m_ex.vj);
    check("m_ex_Vk",    ex_Vk,  m_ex.vk);
    check("m_ex_imm",   ex_imm, m_ex.imm);
    check("m_ex_pc",    ex_pc,  m_ex.pc);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    rdy = 1'b1; clr = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_RobId = '0; issue_pc = '0; issue_imm = '0;
    issue_Vj = '0; issue_Vk = '0; issue_Rj = 1'b0; issue_Rk = 1'b0;
    issue_Qj = '0; issue_Qk = '0;
    alu_valid = 1'b0; alu_RobId = '0; alu_value = '0;
    lsb_valid = 1'b0; lsb_RobId = '0; lsb_value = '0;
  endtask

  task automatic set_issue(input logic [3:0] rob, input logic rj, input logic [3:0] qj,
                           input logic [31:0] vj, input logic rk, input logic [3:0] qk,
                           input logic [31:0] vk);
    issue_valid = 1'b1; issue_RobId = rob;
    issue_op = 6'(rob) + 6'd1; issue_pc = 32'h1000 + 32'(rob) * 4; issue_imm = 32'(rob) << 4;
    issue_Rj = rj; issue_Qj = qj; issue_Vj = vj;
    issue_Rk = rk; issue_Qk = qk; issue_Vk = vk;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        iv;
    logic [3:0]  rob;
    logic        rj, rk;
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
    logic        av;
    logic [3:0]  at;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lt;
    logic [31:0] lval;
    logic        ev;
    logic [3:0]  erob;
    logic [31:0] evj, evk;
  } vec_t;

  vec_t vecs [19];

  initial begin
    //            iv rob rj rk qj qk vj      vk   av at aval     lv lt lval     ev erob evj     evk
    vecs[0]  = '{1, 5, 1, 1, 0, 0, 3,      4,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 5, 3,      4};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[3]  = '{1, 2, 0, 1, 7, 0, 0,      1,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,      0,   1, 11, 'h99,   0, 0, 0,       0, 0, 0,      0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0,      0,   1, 7, 'h10,    0, 0, 0,       0, 0, 0,      0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 2, 'h10,   1};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[8]  = '{1, 3, 1, 0, 0, 9, 5,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       1, 9, 'h20,    0, 0, 0,      0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 3, 5,      'h20};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[13] = '{1, 4, 0, 1, 6, 0, 0,      2,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0,      0,   1, 6, 'hAA,    1, 6, 'hBB,    0, 0, 0,      0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 4, 'hAA,   2};
    vecs[16] = '{1, 6, 0, 0, 8, 8, 0,      0,   1, 8, 'h33,    0, 0, 0,       0, 0, 0,      0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       1, 6, 'h33,   'h33};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0,      0,   0, 0, 0,       0, 0, 0,       0, 0, 0,      0};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_rs_full",  32'(rs_full),  32'd0);
    check("reset_ex_RobId", 32'(ex_RobId), 32'd0);
    check("reset_ex_Vj",    ex_Vj, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      idle();
      if (vecs[i].iv) set_issue(vecs[i].rob, vecs[i].rj, vecs[i].qj, vecs[i].vj,
                                vecs[i].rk, vecs[i].qk, vecs[i].vk);
      alu_valid = vecs[i].av; alu_RobId = vecs[i].at; alu_value = vecs[i].aval;
      lsb_valid = vecs[i].lv; lsb_RobId = vecs[i].lt; lsb_value = vecs[i].lval;
      tick();
      check($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_ex_RobId", i), 32'(ex_RobId), 32'(vecs[i].erob));
        check($sformatf("vec%0d_ex_Vj", i), ex_Vj, vecs[i].evj);
        check($sformatf("vec%0d_ex_Vk", i), ex_Vk, vecs[i].evk);
      end
    end

    // rdy stall: dispatched outputs hold, stalled issue is dropped
    idle(); set_issue(4'd1, 1, 0, 32'h11, 1, 0, 32'h12); tick();
    idle(); set_issue(4'd2, 1, 0, 32'h21, 1, 0, 32'h22); tick();
    check("stall_pre_ex_RobId", 32'(ex_RobId), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 1'b0; set_issue(4'd3, 1, 0, 32'h31, 1, 0, 32'h32);
      alu_valid = 1'b1; alu_RobId = 4'd0; alu_value = 32'hDEAD;
      tick();
      check("stall_ex_valid", 32'(ex_valid), 32'd1);
      check("stall_ex_RobId", 32'(ex_RobId), 32'd1);
      check("stall_ex_Vj",    ex_Vj, 32'h11);
    end
    idle(); tick();
    check("stall_release_ex_RobId", 32'(ex_RobId), 32'd2);
    check("stall_release_ex_valid", 32'(ex_valid), 32'd1);
    idle(); tick();
    check("stall_drop_issue", 32'(ex_valid), 32'd0);

    // Fill to full, shared-tag wake-up of entries 3 and 9
    for (int i = 0; i < 15; i++) begin
      idle();
      set_issue(4'(i), 0, (i == 3 || i == 9) ? 4'hE : 4'hD, 0, 1, 0, 32'h100 + 32'(i));
      tick();
      if (i == 13) check("full_low_at_14", 32'(rs_full), 32'd0);
    end
    check("full_high_at_15", 32'(rs_full), 32'd1);
    idle(); alu_valid = 1'b1; alu_RobId = 4'hE; alu_value = 32'h77; tick();
    check("wake_no_same_edge_dispatch", 32'(ex_valid), 32'd0);
    idle(); tick();
    check("order_first_RobId", 32'(ex_RobId), 32'd3);
    check("order_first_Vj",    ex_Vj, 32'h77);
    check("full_dropped",      32'(rs_full), 32'd0);
    idle(); tick();
    check("order_second_RobId", 32'(ex_RobId), 32'd9);
    idle(); alu_valid = 1'b1; alu_RobId = 4'hD; alu_value = 32'h55; tick();
    for (int i = 0; i < 14; i++) begin idle(); tick(); end
    check("drain_done", 32'(ex_valid), 32'd0);

    // Flush overrides issue and dispatch
    for (int i = 0; i < 5; i++) begin
      idle(); set_issue(4'(i), 0, 4'hC, 0, 1, 0, 32'h5); tick();
    end
    idle(); set_issue(4'hA, 1, 0, 32'hA1, 1, 0, 32'hA2); tick();
    idle(); clr = 1'b1; set_issue(4'hB, 1, 0, 32'hB1, 1, 0, 32'hB2); tick();
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_rs_full",  32'(rs_full),  32'd0);
    idle(); alu_valid = 1'b1; alu_RobId = 4'hC; alu_value = 32'h9; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check("flush_no_dispatch", 32'(ex_valid), 32'd0);
    end

    // Asynchronous reset between edges with ready work pending
    idle(); set_issue(4'd1, 1, 0, 32'h1, 1, 0, 32'h1); tick();
    idle(); set_issue(4'd2, 1, 0, 32'h2, 1, 0, 32'h2); tick();
    idle(); set_issue(4'd3, 1, 0, 32'h3, 1, 0, 32'h3); tick();
    idle();
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_ex_valid", 32'(ex_valid), 32'd0);
    check("async_rst_rs_full",  32'(rs_full),  32'd0);
    check("async_rst_ex_RobId", 32'(ex_RobId), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      check("post_rst_no_dispatch", 32'(ex_valid), 32'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
      if (!m_full && $urandom_range(0, 2) != 0) begin
        issue_valid = 1'b1;
        issue_op    = 6'($urandom);
        issue_RobId = 4'($urandom);
        issue_pc    = $urandom;
        issue_imm   = $urandom;
        issue_Vj    = $urandom;
        issue_Vk    = $urandom;
        issue_Rj    = ($urandom_range(0, 2) == 0);
        issue_Rk    = ($urandom_range(0, 2) == 0);
        issue_Qj    = 4'($urandom_range(0, 15));
        issue_Qk    = 4'($urandom_range(0, 15));
      end
      alu_valid = 1'($urandom_range(0, 1));
      alu_RobId = 4'($urandom_range(0, 15));
      alu_value = $urandom;
      lsb_valid = 1'($urandom_range(0, 1));
      lsb_RobId = 4'($urandom_range(0, 15));
      lsb_value = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Arithmetic/branch reservation station directly downstream of the issue stage.
- Accepts non-memory instructions with operand values or ROB tags.
- Snoops the ALU and LSB broadcast buses to wake waiting operands.
- Each cycle, dispatches at most one fully-ready entry to the ALU, tagged with its ROB id.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥4).
- ROB_LOG, 4, width of ROB tag.
- OP_LOG, 6, width of opcode field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- rdy  in  1  global ready; when 0, all state and outputs frozen.
- clr  in  1  mispredict flush, synchronous.
- issue_valid  in  1  issue stage sends an instruction this cycle (rs_send_enable).
- issue_op  in  OP_LOG  opcode.
- issue_RobId  in  ROB_LOG  destination ROB entry.
- issue_pc  in  32  instruction PC.
- issue_imm  in  32  immediate.
- issue_Vj / issue_Vk  in  32 each  operand values.
- issue_Rj / issue_Rk  in  1 each  operand ready flags.
- issue_Qj / issue_Qk  in  ROB_LOG each  producer tags (meaningful only when R==0).
- alu_valid, alu_RobId, alu_value  in  1/ROB_LOG/32  ALU result broadcast.
- lsb_valid, lsb_RobId, lsb_value  in  1/ROB_LOG/32  LSB result broadcast.
- rs_full  out  1  fetch/issue must not send next cycle.
- ex_valid  out  1  dispatch strobe to ALU.
- ex_op  out  OP_LOG  dispatched opcode.
- ex_Vj / ex_Vk  out  32 each  dispatched operands.
- ex_imm, ex_pc  out  32 each  dispatched immediate and PC.
- ex_RobId  out  ROB_LOG  dispatched tag.

Behaviour:
- Reset (rst==0, async): all entry valid bits cleared; ex_valid=0; ex_op/ex_Vj/ex_Vk/ex_imm/ex_pc/ex_RobId=0; rs_full=0.
- rdy==0: no state change, no issue accepted, outputs hold their values.
- Entry state: busy, op, RobId, pc, imm, Vj, Rj, Qj, Vk, Rk, Qk.
- Occupancy counter: 0..RS_SIZE. rs_full is registered and equals (count_next ≥ RS_SIZE-1). The one-slot margin covers the instruction already in flight on the cycle full rises.
- Issue:
  - When issue_valid at edge, write into the lowest-index free entry.
  - Issue's own same-cycle CDB forwarding is trusted.
  - Additionally, if issue_Rj==0 and a broadcast matches issue_Qj this cycle, store R=1 with the broadcast value (same for k).
  - issue_valid with no free entry is illegal; the bench asserts it never happens.
- Wake-up: at each edge, every busy entry with Rj==0 and (alu_valid && alu_RobId==Qj) takes Vj=alu_value, Rj=1. Same for LSB and for the k operand. ALU has priority if both buses match the same tag.
- Select:
  - Combinational over registered state: lowest-index busy entry with Rj&&Rk.
  - At the edge, if found: ex_* are loaded from that entry, ex_valid=1, entry freed. Otherwise ex_valid=0.
  - Entries woken or written at edge N are first selectable for edge N+1.
  - Minimum issue→ex_valid latency is 2 edges for a fully ready instruction.
- Simultaneous issue+dispatch in one edge: count unchanged. The new entry may reuse the freed slot only if it is the lowest free index after freeing; the free search uses pre-edge busy bits, so it never reuses the slot.
- clr at edge: all busy bits cleared, count=0, ex_valid=0, rs_full=0. clr overrides issue and dispatch in the same cycle. Async reset overrides clr.
- Tags are compared only for entries with R==0. Broadcasts for tags not held are ignored.

Test Plan:
- Reset mid-operation: fill 3 entries, pull rst low between edges → ex_valid=0 and rs_full=0 immediately; after release, no dispatch occurs.
- Ready issue: op=ADD, RobId=5, Vj=3, Vk=4, Rj=Rk=1 at edge 0 → edge 2 ex_valid=1, ex_RobId=5, ex_Vj=3, ex_Vk=4; edge 3 ex_valid=0.
- Wake-up:
  - Issue RobId=2 with Rj=0, Qj=7, Rk=1, Vk=1.
  - Two cycles later alu_valid, alu_RobId=7, alu_value=0x10 → dispatch on the following-next edge with ex_Vj=0x10.
  - Repeat using the LSB bus on Qk.
- Ordering/full:
  - Issue RS_SIZE-1 non-ready entries → rs_full=1 after the 15th.
  - Wake entry 9 then entry 3 on one ALU broadcast of a shared tag → entry 3 dispatched first, entry 9 next cycle, rs_full drops.
- Flush: 6 busy entries with one ready, assert clr together with issue_valid → next cycle ex_valid=0 and count=0; the subsequent ALU broadcast causes no dispatch.
- rdy stall: ready entry present, rdy=0 for 3 cycles → no dispatch and outputs unchanged; dispatch occurs on the first edge with rdy=1.
